// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the directional loudness scan.
package scan_pkg;

    // Scan sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MOVE    = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        STORE   = 3'd4,
        DONE    = 3'd5
    } scan_state_t;

    // Width of every angle-valued port and register.
    localparam int ANGLE_W = 9;

    // Sum width that can hold `frames` full-scale `lw`-bit values without overflow.
    function automatic int sum_w(input int lw, input int frames);
        return lw + $clog2(frames);
    endfunction

endpackage

// File: rtl/frame_accumulator.sv
// Sums FRAMES loudness results and presents their average (power-of-two divide).
module frame_accumulator
    import scan_pkg::*;
#(
    parameter int LW     = 33,
    parameter int FRAMES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           add_en,
    input  logic [LW-1:0]                  data,
    output logic [$clog2(FRAMES+1)-1:0]    count,
    output logic [LW-1:0]                  avg,
    output logic                           full
);

    localparam int SHIFT = $clog2(FRAMES);
    localparam int SUM_W = sum_w(LW, FRAMES);
    localparam int CNT_W = $clog2(FRAMES + 1);

    logic [SUM_W-1:0] sum_reg;
    logic [CNT_W-1:0] count_reg;

    // Accumulate one result per add_en; clear wipes both sum and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_reg   <= '0;
            count_reg <= '0;
        end else if (clear) begin
            sum_reg   <= '0;
            count_reg <= '0;
        end else if (add_en) begin
            sum_reg   <= sum_reg + SUM_W'(data);
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // FRAMES is a power of two, so the average is just the upper LW bits.
    assign avg   = sum_reg[SHIFT +: LW];
    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(FRAMES));

endmodule

// File: rtl/angle_scan_controller.sv
// Steps the rotator through every angle, settles, averages loudness and
// writes one averaged value per angle while tracking the loudest angle.
module angle_scan_controller
    import scan_pkg::*;
#(
    parameter int LW            = 33,
    parameter int NAngles       = 360,
    parameter int SETTLE_CYCLES = 18432,
    parameter int FRAMES        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               loudness_valid,
    input  logic [LW-1:0]      loudness,
    input  logic               step_ack,
    output logic               step_req,
    output logic [ANGLE_W-1:0] angle_index,
    output logic               capture_en,
    output logic               wr_en,
    output logic [ANGLE_W-1:0] wr_angle,
    output logic [LW-1:0]      wr_value,
    output logic [ANGLE_W-1:0] best_angle,
    output logic [LW-1:0]      best_loudness,
    output logic               busy,
    output logic               done
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = $clog2(FRAMES + 1);

    scan_state_t        state_reg, state_next;
    logic [ANGLE_W-1:0] angle_reg, angle_next;
    logic [SET_W-1:0]   settle_reg, settle_next;
    logic [ANGLE_W-1:0] best_angle_reg, best_angle_next;
    logic [LW-1:0]      best_loud_reg, best_loud_next;

    logic               acc_clear;
    logic               acc_add;
    logic [CNT_W-1:0]   acc_count;
    logic [LW-1:0]      acc_avg;
    logic               acc_full;
    logic               frame_last;

    // Only strobes that arrive while actually capturing are averaged.
    assign acc_add    = (state_reg == CAPTURE) && loudness_valid;
    assign frame_last = (acc_count == CNT_W'(FRAMES - 1));

    frame_accumulator #(
        .LW     (LW),
        .FRAMES (FRAMES)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear),
        .add_en (acc_add),
        .data   (loudness),
        .count  (acc_count),
        .avg    (acc_avg),
        .full   (acc_full)
    );

    // State, angle, settle counter and best-so-far registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            angle_reg      <= '0;
            settle_reg     <= '0;
            best_angle_reg <= '0;
            best_loud_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            angle_reg      <= angle_next;
            settle_reg     <= settle_next;
            best_angle_reg <= best_angle_next;
            best_loud_reg  <= best_loud_next;
        end
    end

    // Next-state logic; every register holds unless a state says otherwise.
    always_comb begin
        state_next      = state_reg;
        angle_next      = angle_reg;
        settle_next     = settle_reg;
        best_angle_next = best_angle_reg;
        best_loud_next  = best_loud_reg;
        acc_clear       = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                // A new scan restarts from angle 0 with a clean best tracker.
                if (start) begin
                    state_next      = MOVE;
                    angle_next      = '0;
                    settle_next     = '0;
                    best_angle_next = '0;
                    best_loud_next  = '0;
                    acc_clear       = 1'b1;
                end
            end
            MOVE: begin
                if (step_ack) begin
                    state_next  = SETTLE;
                    settle_next = SET_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                // Counter runs N-1 down to 0, giving exactly SETTLE_CYCLES cycles here.
                if (settle_reg == '0) begin
                    state_next = CAPTURE;
                end else begin
                    settle_next = settle_reg - SET_W'(1);
                end
            end
            CAPTURE: begin
                if (acc_full || (loudness_valid && frame_last)) begin
                    state_next = STORE;
                end
            end
            STORE: begin
                acc_clear = 1'b1;
                // Strict compare: on a tie the earlier (lower) angle is kept.
                if (acc_avg > best_loud_reg) begin
                    best_angle_next = angle_reg;
                    best_loud_next  = acc_avg;
                end
                if (angle_reg == ANGLE_W'(NAngles - 1)) begin
                    state_next = DONE;
                end else begin
                    angle_next = angle_reg + ANGLE_W'(1);
                    state_next = MOVE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registered state; all read 0 in IDLE.
    assign step_req      = (state_reg == MOVE);
    assign capture_en    = (state_reg == CAPTURE);
    assign wr_en         = (state_reg == STORE);
    assign wr_angle      = (state_reg == STORE) ? angle_reg : '0;
    assign wr_value      = (state_reg == STORE) ? acc_avg : '0;
    assign busy          = (state_reg == MOVE) || (state_reg == SETTLE) ||
                           (state_reg == CAPTURE) || (state_reg == STORE);
    assign done          = (state_reg == DONE);
    assign angle_index   = angle_reg;
    assign best_angle    = best_angle_reg;
    assign best_loudness = best_loud_reg;

endmodule

// File: tb/tb_angle_scan_controller.sv
// Directed bench for the angle scan controller (4 angles, settle 3, 2 frames).
module tb_angle_scan_controller;

    localparam int LW = 33;
    localparam logic [LW-1:0] MAXV = {LW{1'b1}};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          loudness_valid = 1'b0;
    logic [LW-1:0] loudness = '0;
    logic          step_ack = 1'b0;
    logic          step_req;
    logic [8:0]    angle_index;
    logic          capture_en;
    logic          wr_en;
    logic [8:0]    wr_angle;
    logic [LW-1:0] wr_value;
    logic [8:0]    best_angle;
    logic [LW-1:0] best_loudness;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_mis = 0;

    logic [8:0]    q_ang[$];
    logic [LW-1:0] q_val[$];

    angle_scan_controller #(
        .LW            (LW),
        .NAngles       (4),
        .SETTLE_CYCLES (3),
        .FRAMES        (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .loudness_valid (loudness_valid),
        .loudness       (loudness),
        .step_ack       (step_ack),
        .step_req       (step_req),
        .angle_index    (angle_index),
        .capture_en     (capture_en),
        .wr_en          (wr_en),
        .wr_angle       (wr_angle),
        .wr_value       (wr_value),
        .best_angle     (best_angle),
        .best_loudness  (best_loudness),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Record every store write, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) begin
            q_ang.push_back(wr_angle);
            q_val.push_back(wr_value);
            $display("wr angle=%0d value=%0d", wr_angle, wr_value);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 100 && !step_req; i++) tick();
        check("wait_step_req", step_req, 1);
    endtask

    task automatic wait_cap();
        for (int i = 0; i < 100 && !capture_en; i++) tick();
        check("wait_capture_en", capture_en, 1);
    endtask

    // One angle: acknowledge the step, optionally verify settle timing, feed two frames.
    task automatic serve_angle(input int ack_dly, input logic [LW-1:0] l0,
                               input logic [LW-1:0] l1, input bit chk);
        wait_req();
        repeat (ack_dly) tick();
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        if (chk) begin
            check("step_req_drop", step_req, 0);
            check("settle_t1", capture_en, 0);
            tick();
            check("settle_t2", capture_en, 0);
            loudness_valid = 1'b1;
            loudness = 33'd1000;
            tick();
            loudness_valid = 1'b0;
            check("settle_t3", capture_en, 0);
            tick();
            check("capture_t4", capture_en, 1);
        end else begin
            wait_cap();
        end
        loudness_valid = 1'b1;
        loudness = l0;
        tick();
        loudness = l1;
        tick();
        loudness_valid = 1'b0;
        check("store_wr_en", wr_en, 1);
        tick();
    endtask

    task automatic check_writes(input logic [LW-1:0] e0, input logic [LW-1:0] e1,
                                input logic [LW-1:0] e2, input logic [LW-1:0] e3);
        logic [LW-1:0] ev[4];
        ev = '{e0, e1, e2, e3};
        check("wr_count", q_ang.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_ang.size()) begin
                check("wr_angle", q_ang[i], i);
                check("wr_value", q_val[i], ev[i]);
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_step_req", step_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", wr_en, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Test 1 + 2: full scan, settle timing checked on angle 0
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_step_req", step_req, 1);
        check("t1_busy", busy, 1);
        check("t1_angle0", angle_index, 0);
        serve_angle(2, 33'd10, 33'd20, 1'b1);
        serve_angle(2, 33'd50, 33'd70, 1'b0);
        serve_angle(2, 33'd5, 33'd5, 1'b0);
        serve_angle(2, 33'd60, 33'd60, 1'b0);
        check_writes(33'd15, 33'd60, 33'd5, 33'd60);
        check("t1_best_angle", best_angle, 1);
        check("t1_best_loud", best_loudness, 60);
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 0);

        // Test 3 + 4: restart from DONE, max-value sum, start ignored during CAPTURE
        q_ang.delete();
        q_val.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_angle_reset", angle_index, 0);
        check("t4_best_reset", best_loudness, 0);
        check("t4_move", step_req, 1);
        check("t4_done_low", done, 0);
        repeat (1) tick();
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        wait_cap();
        loudness_valid = 1'b1;
        loudness = MAXV;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_cap_kept", capture_en, 1);
        check("t4_angle_kept", angle_index, 0);
        tick();
        loudness_valid = 1'b0;
        check("t3_wr_en", wr_en, 1);
        check("t3_wr_value", wr_value, MAXV);
        tick();
        serve_angle(1, 33'd7, 33'd9, 1'b0);
        serve_angle(1, 33'd100, 33'd200, 1'b0);
        serve_angle(1, 33'd0, 33'd2, 1'b0);
        check_writes(MAXV, 33'd8, 33'd150, 33'd1);
        check("t3_best_angle", best_angle, 0);
        check("t3_best_loud", best_loudness, MAXV);
        check("t3_done", done, 1);

        // Test 5: async reset mid-SETTLE at angle 2
        start = 1'b1;
        tick();
        start = 1'b0;
        serve_angle(1, 33'd20, 33'd40, 1'b0);
        serve_angle(1, 33'd100, 33'd0, 1'b0);
        wait_req();
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        tick();
        check("t5_pre_angle", angle_index, 2);
        check("t5_pre_best", best_loudness, 50);
        check("t5_pre_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("t5_step_req", step_req, 0);
        check("t5_capture_en", capture_en, 0);
        check("t5_wr_en", wr_en, 0);
        check("t5_wr_angle", wr_angle, 0);
        check("t5_wr_value", wr_value, 0);
        check("t5_angle", angle_index, 0);
        check("t5_best_angle", best_angle, 0);
        check("t5_best_loud", best_loudness, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q_ang.delete();
        q_val.delete();
        repeat (20) tick();
        check("t5_no_writes", q_ang.size(), 0);
        check("t5_idle_busy", busy, 0);
        check("t5_idle_req", step_req, 0);

        // Test 6: step_ack held high, one-cycle MOVE, scan completes
        step_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_move", step_req, 1);
        tick();
        check("t6_move_1cyc", step_req, 0);
        for (int a = 0; a < 4; a++) begin
            logic [LW-1:0] la[4];
            logic [LW-1:0] lb[4];
            la = '{33'd1, 33'd8, 33'd4, 33'd9};
            lb = '{33'd3, 33'd8, 33'd6, 33'd7};
            wait_cap();
            loudness_valid = 1'b1;
            loudness = la[a];
            tick();
            loudness = lb[a];
            tick();
            loudness_valid = 1'b0;
            tick();
        end
        step_ack = 1'b0;
        check_writes(33'd2, 33'd8, 33'd5, 33'd8);
        check("t6_best_angle", best_angle, 1);
        check("t6_best_loud", best_loudness, 8);
        check("t6_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
